// File: rtl/relu_pkg.sv
// Shared types for the ReLU forward/backward layer blocks.
package relu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/relu_grad_sat.sv
// Combinational arithmetic right shift of a signed gradient followed by
// saturation to the narrower output width; ovf_o flags a clamp.
module relu_grad_sat #(
  parameter int gradbits = 16,
  parameter int outbits  = 8,
  parameter int shift    = 0
) (
  input  logic signed [gradbits-1:0] g_i,
  output logic signed [outbits-1:0]  val_o,
  output logic                       ovf_o
);

  logic signed [gradbits-1:0] shifted;

  // >>> on a signed operand rounds toward -inf, which is the required truncation.
  assign shifted = g_i >>> shift;

  if (outbits < gradbits) begin : g_clip
    localparam logic signed [gradbits-1:0] MAXV = gradbits'((1 << (outbits-1)) - 1);
    localparam logic signed [gradbits-1:0] MINV = ~MAXV;

    always_comb begin
      val_o = shifted[outbits-1:0];
      ovf_o = 1'b0;
      if (shifted > MAXV) begin
        val_o = {1'b0, {(outbits-1){1'b1}}};
        ovf_o = 1'b1;
      end else if (shifted < MINV) begin
        val_o = {1'b1, {(outbits-1){1'b0}}};
        ovf_o = 1'b1;
      end
    end
  end else begin : g_ext
    assign val_o = outbits'(shifted);
    assign ovf_o = 1'b0;
  end

endmodule

// File: rtl/relu_backward.sv
// Element-serial ReLU backward pass: dx[i] = sat(g[i] >>> shift) where x[i] > 0,
// else 0, one element per clock, with active count and sticky saturation flag.
module relu_backward
  import relu_pkg::*;
#(
  parameter int inbits   = 8,
  parameter int gradbits = 16,
  parameter int outbits  = 8,
  parameter int shift    = 0,
  parameter int size     = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [inbits-1:0]      x  [0:size-1],
  input  logic signed [gradbits-1:0]    g  [0:size-1],
  output logic signed [outbits-1:0]     dx [0:size-1],
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(size+1)-1:0]     active_count,
  output logic                          sat
);

  localparam int IW = (size > 1) ? $clog2(size) : 1;
  localparam int CW = $clog2(size + 1);
  localparam logic [IW-1:0] LAST = IW'(size - 1);

  state_t                     state_q;
  logic [IW-1:0]              idx_q;
  logic [CW-1:0]              cnt_q;
  logic                       sat_q;
  logic                       busy_q;
  logic                       done_q;
  logic signed [outbits-1:0]  dx_q [0:size-1];

  logic signed [inbits-1:0]   x_cur;
  logic signed [gradbits-1:0] g_cur;
  logic signed [outbits-1:0]  g_sat;
  logic                       g_ovf;
  logic                       mask;

  assign x_cur = x[idx_q];
  assign g_cur = g[idx_q];
  // Strictly positive: sign bit clear and not all-zero.
  assign mask  = ~x_cur[inbits-1] & (|x_cur);

  relu_grad_sat #(
    .gradbits (gradbits),
    .outbits  (outbits),
    .shift    (shift)
  ) u_sat (
    .g_i   (g_cur),
    .val_o (g_sat),
    .ovf_o (g_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < size; k++) dx_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          dx_q[idx_q] <= mask ? g_sat : '0;
          if (mask) cnt_q <= cnt_q + CW'(1);
          if (mask && g_ovf) sat_q <= 1'b1;
          if (idx_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dx           = dx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign active_count = cnt_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_relu_backward.sv
// Randomized self-checking bench for relu_backward: three instances
// (size 4 / shift 0, size 4 / shift 4, size 1 / shift 0) against a behavioural model.
module tb_relu_backward;

  localparam int OB   = 8;
  localparam int MAXO = (1 << (OB-1)) - 1;
  localparam int MINO = -(1 << (OB-1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, start_b, start_c;
  logic signed [7:0]  xa [0:3];
  logic signed [15:0] ga [0:3];
  logic signed [7:0]  dxa [0:3];
  logic busy_a, done_a, sat_a;
  logic [2:0] cnt_a;

  logic signed [7:0]  xb [0:3];
  logic signed [15:0] gb [0:3];
  logic signed [7:0]  dxb [0:3];
  logic busy_b, done_b, sat_b;
  logic [2:0] cnt_b;

  logic signed [7:0]  xc [0:0];
  logic signed [15:0] gc [0:0];
  logic signed [7:0]  dxc [0:0];
  logic busy_c, done_c, sat_c;
  logic [0:0] cnt_c;

  relu_backward #(.inbits(8), .gradbits(16), .outbits(8), .shift(0), .size(4)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .x(xa), .g(ga), .dx(dxa),
    .busy(busy_a), .done(done_a), .active_count(cnt_a), .sat(sat_a));

  relu_backward #(.inbits(8), .gradbits(16), .outbits(8), .shift(4), .size(4)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .x(xb), .g(gb), .dx(dxb),
    .busy(busy_b), .done(done_b), .active_count(cnt_b), .sat(sat_b));

  relu_backward #(.inbits(8), .gradbits(16), .outbits(8), .shift(0), .size(1)) dut_c (
    .clk(clk), .reset(rst), .start(start_c), .x(xc), .g(gc), .dx(dxc),
    .busy(busy_c), .done(done_c), .active_count(cnt_c), .sat(sat_c));

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference for one element: floor division by 2^sh, then clamp if active.
  function automatic void ref_el(input int xv, input int gv, input int sh,
                                 output int dv, output bit act, output bit ov);
    int p, v;
    p = 1 << sh;
    if (gv >= 0) v = gv / p;
    else         v = -((-gv + p - 1) / p);
    act = (xv > 0);
    ov  = 1'b0;
    dv  = 0;
    if (act) begin
      if (v > MAXO)      begin dv = MAXO; ov = 1'b1; end
      else if (v < MINO) begin dv = MINO; ov = 1'b1; end
      else               dv = v;
    end
  endfunction

  // Model for instance A: a pass result is computed at start; element j
  // becomes visible j+1 edges later, done after all 4.
  bit m_run = 1'b0, m_done = 1'b0;
  int m_el = 0;
  int m_dx [0:3] = '{0, 0, 0, 0};
  int e_dx [0:3] = '{0, 0, 0, 0};
  bit e_act [0:3] = '{0, 0, 0, 0};
  bit e_ov  [0:3] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; m_el = 0;
      for (int j = 0; j < 4; j++) m_dx[j] = 0;
    end else if (m_run) begin
      m_dx[m_el] = e_dx[m_el];
      m_el++;
      if (m_el == 4) begin m_run = 1'b0; m_done = 1'b1; end
    end else if (start_a) begin
      m_run = 1'b1; m_done = 1'b0; m_el = 0;
      for (int j = 0; j < 4; j++) ref_el(int'(xa[j]), int'(ga[j]), 0, e_dx[j], e_act[j], e_ov[j]);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int ec;
      bit es;
      ec = 0; es = 1'b0;
      for (int j = 0; j < m_el; j++) begin
        ec += int'(e_act[j]);
        es |= e_ov[j];
      end
      chk("a_busy", int'(busy_a), int'(m_run));
      chk("a_done", int'(done_a), int'(m_done));
      chk("a_count", int'(cnt_a), ec);
      chk("a_sat", int'(sat_a), int'(es));
      for (int j = 0; j < 4; j++) chk($sformatf("a_dx%0d", j), int'(dxa[j]), m_dx[j]);
    end
  end

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic dn(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Pulse start (optionally re-pulse during RUN) and count edges until done.
  task automatic run(input int w, input bit extra, output int lat);
    @(negedge clk); set_start(w, 1'b1);
    @(negedge clk); set_start(w, extra);
    lat = 0;
    if (extra) begin
      @(negedge clk); set_start(w, 1'b0);
      lat = 1;
    end
    while (!dn(w) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!dn(w)) chk($sformatf("timeout_dut%0d", w), 0, 1);
  endtask

  task automatic check_b_pass(input int lat);
    int dv, ec;
    bit act, ov, es;
    ec = 0; es = 1'b0;
    chk("b_latency", lat, 4);
    for (int j = 0; j < 4; j++) begin
      ref_el(int'(xb[j]), int'(gb[j]), 4, dv, act, ov);
      chk($sformatf("b_dx%0d", j), int'(dxb[j]), dv);
      ec += int'(act);
      es |= ov;
    end
    chk("b_count", int'(cnt_b), ec);
    chk("b_sat", int'(sat_b), int'(es));
  endtask

  function automatic logic signed [15:0] rand_g();
    if ($urandom_range(0, 1) == 1) return 16'($urandom_range(0, 600)) - 16'sd300;
    return 16'($urandom);
  endfunction

  initial begin
    int lat;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    xa = '{0, 0, 0, 0}; ga = '{0, 0, 0, 0};
    xb = '{0, 0, 0, 0}; gb = '{0, 0, 0, 0};
    xc = '{0}; gc = '{0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_count", int'(cnt_a), 0);

    // Basic masking.
    xa = '{5, -3, 0, 127}; ga = '{10, 20, 30, -40};
    run(0, 1'b0, lat);
    chk("s1_latency", lat, 4);
    chk("s1_dx0", int'(dxa[0]), 10);
    chk("s1_dx1", int'(dxa[1]), 0);
    chk("s1_dx2", int'(dxa[2]), 0);
    chk("s1_dx3", int'(dxa[3]), -40);
    chk("s1_count", int'(cnt_a), 2);
    chk("s1_sat", int'(sat_a), 0);

    // Saturation; masked 500 must not set sat.
    xa = '{1, 1, 1, -1}; ga = '{300, -300, 127, 500};
    run(0, 1'b0, lat);
    chk("s2_dx0", int'(dxa[0]), 127);
    chk("s2_dx1", int'(dxa[1]), -128);
    chk("s2_dx2", int'(dxa[2]), 127);
    chk("s2_dx3", int'(dxa[3]), 0);
    chk("s2_sat", int'(sat_a), 1);
    chk("s2_count", int'(cnt_a), 3);

    // Start during RUN ignored, then restart from DONE.
    xa = '{5, -3, 0, 127}; ga = '{10, 20, 30, -40};
    run(0, 1'b1, lat);
    chk("s5_latency", lat, 4);
    xa = '{-1, 2, 3, 0}; ga = '{7, 400, -9, 1};
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("s5_done_fall", int'(done_a), 0);
    chk("s5_busy", int'(busy_a), 1);
    chk("s5_count_clr", int'(cnt_a), 0);
    chk("s5_sat_clr", int'(sat_a), 0);
    lat = 0;
    while (!done_a && lat < 50) begin @(negedge clk); lat++; end
    chk("s5_relatency", lat, 4);
    chk("s5_dx1", int'(dxa[1]), 127);
    chk("s5_dx2", int'(dxa[2]), -9);
    chk("s5_sat", int'(sat_a), 1);

    // Reset two cycles after start.
    xa = '{5, -3, 0, 127}; ga = '{10, 20, 30, -40};
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); rst = 1'b1; start_a = 1'b1;
    @(negedge clk); rst = 1'b0; start_a = 1'b0;
    chk("s4_busy", int'(busy_a), 0);
    chk("s4_done", int'(done_a), 0);
    chk("s4_count", int'(cnt_a), 0);
    for (int j = 0; j < 4; j++) chk($sformatf("s4_dx%0d", j), int'(dxa[j]), 0);
    run(0, 1'b0, lat);
    chk("s4_latency", lat, 4);
    chk("s4_dx0", int'(dxa[0]), 10);
    chk("s4_dx3", int'(dxa[3]), -40);
    chk("s4_count2", int'(cnt_a), 2);

    // Shift by 4.
    xb = '{1, 1, 1, 1}; gb = '{-1, 256, -17, 2047};
    run(1, 1'b0, lat);
    chk("s3_dx0", int'(dxb[0]), -1);
    chk("s3_dx1", int'(dxb[1]), 16);
    chk("s3_dx2", int'(dxb[2]), -2);
    chk("s3_dx3", int'(dxb[3]), 127);
    chk("s3_sat", int'(sat_b), 0);
    chk("s3_count", int'(cnt_b), 4);

    // size = 1: busy exactly one cycle.
    xc = '{0}; gc = '{-5};
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    chk("s6_busy1", int'(busy_c), 1);
    chk("s6_done0", int'(done_c), 0);
    @(negedge clk);
    chk("s6_busy2", int'(busy_c), 0);
    chk("s6_done1", int'(done_c), 1);
    chk("s6_dx", int'(dxc[0]), 0);
    chk("s6_count", int'(cnt_c), 0);
    xc = '{9}; gc = '{-200};
    run(2, 1'b0, lat);
    chk("s6b_latency", lat, 1);
    chk("s6b_dx", int'(dxc[0]), -128);
    chk("s6b_count", int'(cnt_c), 1);
    chk("s6b_sat", int'(sat_c), 1);

    // Randomized passes; A is checked every cycle by the model.
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 4; j++) begin
        xa[j] = ($urandom_range(0, 3) == 0) ? 8'sd0 : 8'($urandom);
        ga[j] = rand_g();
        xb[j] = 8'($urandom);
        gb[j] = rand_g();
      end
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end else begin
        run(0, 1'(($urandom_range(0, 2) == 0)), lat);
        chk("rnd_a_latency", lat, 4);
      end
      run(1, 1'b0, lat);
      check_b_pass(lat);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
